// File: rtl/dbus_mbox.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dbus_mbox : per-core receive FIFOs fed by round-robin arbitrated pushes  |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
module dbus_mbox #(
    parameter int NCORES = 2,
    parameter int DEPTH  = 8,
    parameter int ADDRW  = 6
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NCORES-1:0]       re_packed_i,
    input  logic [NCORES-1:0]       we_packed_i,
    input  logic [ADDRW*NCORES-1:0] addr_packed_i,
    input  logic [32*NCORES-1:0]    wdata_packed_i,
    output logic [32*NCORES-1:0]    rdata_packed_o,
    output logic [NCORES-1:0]       stall_packed_o
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam int c_PW = (NCORES > 1) ? $clog2(NCORES) : 1;
    localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

    logic [3:0]        w_word      [NCORES];
    logic [NCORES-1:0] w_rd;
    logic [NCORES-1:0] w_clr;
    logic [NCORES-1:0] w_pop;
    logic [NCORES-1:0] w_req       [NCORES];
    logic [NCORES-1:0] w_gnt_vld;
    logic [c_PW-1:0]   w_gnt_id    [NCORES];
    logic [c_PW-1:0]   w_rr_nxt    [NCORES];
    logic [c_PW-1:0]   w_rr        [NCORES];
    logic [c_CW-1:0]   w_cnt       [NCORES];
    logic [31:0]       w_push_data [NCORES];
    logic [NCORES-1:0] w_push_ok;
    logic [NCORES-1:0] w_drop;
    logic [NCORES-1:0] w_stall;
    logic              w_unused_addr;

    // Byte-lane bits of the offset carry no meaning here.
    assign w_unused_addr = ^addr_packed_i;

    always_comb begin : p_decode
        for (int k = 0; k < NCORES; k++) begin
            w_word[k] = addr_packed_i[ADDRW*k+2 +: 4];
            w_rd[k]   = ~rst_i & re_packed_i[k] & ~we_packed_i[k];
            w_clr[k]  = ~rst_i & we_packed_i[k] & (w_word[k] == 4'd1)
                        & wdata_packed_i[32*k+31];
            w_pop[k]  = w_rd[k] & (w_word[k] == 4'd0) & (w_cnt[k] != '0);
        end
        for (int d = 0; d < NCORES; d++) begin
            for (int k = 0; k < NCORES; k++) begin
                w_req[d][k] = ~rst_i & we_packed_i[k] & w_word[k][3]
                              & (int'(w_word[k][2:0]) == d);
            end
        end
    end

    // Pointer names the core with highest priority for the next contest.
    always_comb begin : p_arb
        int  c;
        int  nx;
        logic found;
        c       = 0;
        nx      = 0;
        found   = 1'b0;
        w_stall = '0;
        for (int d = 0; d < NCORES; d++) begin
            found        = 1'b0;
            w_gnt_vld[d] = 1'b0;
            w_gnt_id[d]  = '0;
            for (int i = 0; i < NCORES; i++) begin
                c = int'(w_rr[d]) + i;
                if (c >= NCORES) begin
                    c = c - NCORES;
                end
                if (!found && w_req[d][c]) begin
                    found       = 1'b1;
                    w_gnt_id[d] = c_PW'(c);
                end
            end
            w_gnt_vld[d] = found;
            nx = int'(w_gnt_id[d]) + 1;
            if (nx >= NCORES) begin
                nx = 0;
            end
            w_rr_nxt[d]    = c_PW'(nx);
            w_push_data[d] = wdata_packed_i[32*int'(w_gnt_id[d]) +: 32];
            w_push_ok[d]   = found & ((w_cnt[d] != c_FULL) | w_pop[d]);
            w_drop[d]      = found & ~((w_cnt[d] != c_FULL) | w_pop[d]);
            for (int k = 0; k < NCORES; k++) begin
                if (w_req[d][k] && (w_gnt_id[d] != c_PW'(k))) begin
                    w_stall[k] = 1'b1;
                end
            end
        end
    end

    assign stall_packed_o = w_stall;

    for (genvar k = 0; k < NCORES; k++) begin : g_core
        logic [31:0]     r_mem [DEPTH];
        logic [c_AW-1:0] r_rptr;
        logic [c_AW-1:0] r_wptr;
        logic [c_CW-1:0] r_cnt;
        logic            r_ovf;
        logic [c_PW-1:0] r_rr;
        logic [31:0]     r_rdata;
        logic [31:0]     w_status;

        assign w_status = {r_ovf, 15'b0, 16'(r_cnt)};

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_rptr  <= '0;
                r_wptr  <= '0;
                r_cnt   <= '0;
                r_ovf   <= 1'b0;
                r_rr    <= '0;
                r_rdata <= '0;
            end else begin
                if (w_push_ok[k]) begin
                    r_wptr <= r_wptr + 1'b1;
                end
                if (w_pop[k]) begin
                    r_rptr <= r_rptr + 1'b1;
                end
                if (w_push_ok[k] && !w_pop[k]) begin
                    r_cnt <= r_cnt + c_ONE;
                end else if (!w_push_ok[k] && w_pop[k]) begin
                    r_cnt <= r_cnt - c_ONE;
                end
                // A drop in the same cycle as a clear keeps the flag set.
                if (w_drop[k]) begin
                    r_ovf <= 1'b1;
                end else if (w_clr[k]) begin
                    r_ovf <= 1'b0;
                end
                if (w_gnt_vld[k]) begin
                    r_rr <= w_rr_nxt[k];
                end
                if (w_rd[k]) begin
                    case (w_word[k])
                        4'd0:    r_rdata <= w_pop[k] ? r_mem[r_rptr] : 32'd0;
                        4'd1:    r_rdata <= w_status;
                        default: r_rdata <= 32'd0;
                    endcase
                end
            end
        end

        always_ff @(posedge clk_i) begin
            if (w_push_ok[k]) begin
                r_mem[r_wptr] <= w_push_data[k];
            end
        end

        assign w_cnt[k]                  = r_cnt;
        assign w_rr[k]                   = r_rr;
        assign rdata_packed_o[32*k +: 32] = r_rdata;
    end

endmodule
`default_nettype wire

// File: tb/tb_dbus_mbox.sv
`default_nettype none
// Directed bench for dbus_mbox: vector table plus hand-built corner sequences.
module tb_dbus_mbox;

    localparam int NC  = 2;
    localparam int DP  = 8;
    localparam int AWD = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    re;
    logic [1:0]    we;
    logic [11:0]   addr;
    logic [63:0]   wdata;
    logic [63:0]   rdata;
    logic [1:0]    stall;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dbus_mbox #(.NCORES(NC), .DEPTH(DP), .ADDRW(AWD)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .re_packed_i    (re),
        .we_packed_i    (we),
        .addr_packed_i  (addr),
        .wdata_packed_i (wdata),
        .rdata_packed_o (rdata),
        .stall_packed_o (stall)
    );

    typedef struct {
        logic [1:0]  re;
        logic [1:0]  we;
        logic [5:0]  a0;
        logic [5:0]  a1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  stall;
        logic [31:0] r0;
        logic [31:0] r1;
    } vec_t;

    vec_t tbl [19];

    function automatic vec_t mk(input logic [1:0] r, input logic [1:0] w,
                                input logic [5:0] a0, input logic [5:0] a1,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [1:0] st,
                                input logic [31:0] r0, input logic [31:0] r1);
        vec_t v;
        v.re = r;  v.we = w;  v.a0 = a0; v.a1 = a1;
        v.d0 = d0; v.d1 = d1; v.stall = st; v.r0 = r0; v.r1 = r1;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] r, input logic [1:0] w,
                         input logic [5:0] a0, input logic [5:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1);
        @(negedge clk);
        re    = r;
        we    = w;
        addr  = {a1, a0};
        wdata = {d1, d0};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [1:0] r, input logic [1:0] w,
                        input logic [5:0] a0, input logic [5:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1);
        drive(r, w, a0, a1, d0, d1);
        tick();
    endtask

    // core0 pushes to RX[1]; core1 pops / reads status of RX[1]
    task automatic push1(input logic [31:0] d);
        step(2'b00, 2'b01, 6'h24, 6'h00, d, 32'h0);
    endtask

    task automatic rd1(input logic [5:0] a, input string nm, input logic [31:0] exp);
        step(2'b10, 2'b00, 6'h00, a, 32'h0, 32'h0);
        check(nm, rdata[63:32], exp);
    endtask

    initial begin
        rst   = 1'b1;
        re    = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;

        tbl[0]  = mk(2'b00, 2'b00, 6'h00, 6'h00, 32'h0, 32'h0, 2'b00, 32'h0, 32'h0);
        tbl[1]  = mk(2'b00, 2'b01, 6'h25, 6'h00, 32'hA5A5_0001, 32'h0, 2'b00, 32'h0, 32'h0);
        tbl[2]  = mk(2'b10, 2'b00, 6'h00, 6'h04, 32'h0, 32'h0, 2'b00, 32'h0, 32'h1);
        tbl[3]  = mk(2'b10, 2'b00, 6'h00, 6'h00, 32'h0, 32'h0, 2'b00, 32'h0, 32'hA5A5_0001);
        tbl[4]  = mk(2'b10, 2'b00, 6'h00, 6'h07, 32'h0, 32'h0, 2'b00, 32'h0, 32'h0);
        tbl[5]  = mk(2'b00, 2'b11, 6'h20, 6'h20, 32'h11, 32'h22, 2'b10, 32'h0, 32'h0);
        tbl[6]  = mk(2'b00, 2'b11, 6'h20, 6'h20, 32'h33, 32'h22, 2'b01, 32'h0, 32'h0);
        tbl[7]  = mk(2'b00, 2'b01, 6'h20, 6'h00, 32'h33, 32'h0, 2'b00, 32'h0, 32'h0);
        tbl[8]  = mk(2'b01, 2'b00, 6'h00, 6'h00, 32'h0, 32'h0, 2'b00, 32'h11, 32'h0);
        tbl[9]  = mk(2'b01, 2'b00, 6'h00, 6'h00, 32'h0, 32'h0, 2'b00, 32'h22, 32'h0);
        tbl[10] = mk(2'b01, 2'b00, 6'h00, 6'h00, 32'h0, 32'h0, 2'b00, 32'h33, 32'h0);
        tbl[11] = mk(2'b01, 2'b00, 6'h08, 6'h00, 32'h0, 32'h0, 2'b00, 32'h0, 32'h0);
        tbl[12] = mk(2'b00, 2'b01, 6'h24, 6'h00, 32'h55, 32'h0, 2'b00, 32'h0, 32'h0);
        tbl[13] = mk(2'b10, 2'b00, 6'h00, 6'h04, 32'h0, 32'h0, 2'b00, 32'h0, 32'h1);
        tbl[14] = mk(2'b10, 2'b10, 6'h00, 6'h20, 32'h0, 32'h66, 2'b00, 32'h0, 32'h1);
        tbl[15] = mk(2'b01, 2'b00, 6'h00, 6'h00, 32'h0, 32'h0, 2'b00, 32'h66, 32'h1);
        tbl[16] = mk(2'b10, 2'b00, 6'h00, 6'h00, 32'h0, 32'h0, 2'b00, 32'h66, 32'h55);
        tbl[17] = mk(2'b00, 2'b10, 6'h00, 6'h28, 32'h0, 32'h99, 2'b00, 32'h66, 32'h55);
        tbl[18] = mk(2'b11, 2'b00, 6'h04, 6'h04, 32'h0, 32'h0, 2'b00, 32'h0, 32'h0);

        // Reset state, including requests presented while reset is held.
        repeat (2) @(posedge clk);
        #1;
        check("reset.rdata0", rdata[31:0], 32'h0);
        check("reset.rdata1", rdata[63:32], 32'h0);
        we   = 2'b11;
        addr = {6'h20, 6'h20};
        #1;
        check("reset.stall", {30'h0, stall}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        we  = 2'b00;

        foreach (tbl[i]) begin
            drive(tbl[i].re, tbl[i].we, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1);
            #1;
            check($sformatf("vec%0d.stall", i), {30'h0, stall}, {30'h0, tbl[i].stall});
            tick();
            check($sformatf("vec%0d.r0", i), rdata[31:0], tbl[i].r0);
            check($sformatf("vec%0d.r1", i), rdata[63:32], tbl[i].r1);
        end

        // Overflow: DEPTH+1 pushes, last dropped, then clear via STATUS write.
        for (int i = 0; i <= DP; i++) begin
            push1(32'hB000_0000 + i);
        end
        rd1(6'h04, "ovf.status", 32'h8000_0000 | DP);
        step(2'b00, 2'b10, 6'h00, 6'h04, 32'h0, 32'h8000_0000);
        rd1(6'h04, "ovf.cleared", DP);

        // Full FIFO push accepted because owner pops in the same cycle.
        step(2'b10, 2'b01, 6'h24, 6'h00, 32'h77, 32'h0);
        check("fullpop.head", rdata[63:32], 32'hB000_0000);
        rd1(6'h04, "fullpop.status", DP);
        for (int i = 1; i < DP; i++) begin
            rd1(6'h00, $sformatf("fullpop.pop%0d", i), 32'hB000_0000 + i);
        end
        rd1(6'h00, "fullpop.last", 32'h77);

        // Empty pop, then push and pop together on an empty FIFO.
        rd1(6'h00, "empty.pop", 32'h0);
        rd1(6'h04, "empty.status", 32'h0);
        step(2'b10, 2'b01, 6'h24, 6'h00, 32'hE0, 32'h0);
        check("emptypp.pop", rdata[63:32], 32'h0);
        rd1(6'h04, "emptypp.status", 32'h1);
        rd1(6'h00, "emptypp.data", 32'hE0);

        // Pointer wrap over 3*DEPTH push/pop pairs.
        for (int i = 0; i < 3*DP; i++) begin
            push1(32'h1000 + i);
            rd1(6'h00, $sformatf("wrap%0d", i), 32'h1000 + i);
        end

        // Simultaneous push and pop on a non-empty FIFO.
        push1(32'hA1);
        step(2'b10, 2'b01, 6'h24, 6'h00, 32'hA2, 32'h0);
        check("pp.oldhead", rdata[63:32], 32'hA1);
        rd1(6'h04, "pp.status", 32'h1);
        rd1(6'h00, "pp.newdata", 32'hA2);

        // Async reset between edges with RX[0] holding three words.
        for (int i = 1; i <= 3; i++) begin
            step(2'b00, 2'b10, 6'h00, 6'h20, 32'h0, i);
        end
        push1(32'hCC);
        step(2'b11, 2'b00, 6'h04, 6'h04, 32'h0, 32'h0);
        check("pre_rst.r0", rdata[31:0], 32'h3);
        check("pre_rst.r1", rdata[63:32], 32'h1);
        @(negedge clk);
        #2;
        rst  = 1'b1;
        re   = 2'b00;
        we   = 2'b11;
        addr = {6'h20, 6'h20};
        #1;
        check("arst.r0", rdata[31:0], 32'h0);
        check("arst.r1", rdata[63:32], 32'h0);
        check("arst.stall", {30'h0, stall}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        we  = 2'b00;
        step(2'b11, 2'b00, 6'h04, 6'h04, 32'h0, 32'h0);
        check("post_rst.status0", rdata[31:0], 32'h0);
        check("post_rst.status1", rdata[63:32], 32'h0);
        step(2'b11, 2'b00, 6'h00, 6'h00, 32'h0, 32'h0);
        check("post_rst.pop0", rdata[31:0], 32'h0);
        check("post_rst.pop1", rdata[63:32], 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
